// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//   Decode-stage controller that sequences the branch comparator of the
//   pipelined MIPS core. A branch in D is held until its operands are
//   available through forwarding. The operands are then registered into the
//   comparator. The comparator result is sampled one cycle later to issue a
//   single-cycle PC redirect for taken branches. The block also keeps
//   saturating branch/taken statistics and a sticky stall watchdog.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   flush                   abort any branch in flight (exception/eret)
//   d_valid, d_is_branch    D-stage instruction qualifiers
//   d_cmpop, d_pc, d_imm16  comparator opcode, branch PC, word offset
//   rs_ready, rt_ready      operand availability from the hazard unit
//   rs_val, rt_val          forwarded operand values
//   cmp_bmove               comparator result for cmp_op/cmp_a/cmp_b
//   cmp_op, cmp_a, cmp_b    registered comparator inputs
//   stall_d                 freeze F/D registers
//   redirect, redirect_pc   one-cycle PC load request and branch target
//   busy                    a branch is being resolved
//   branch_cnt, taken_cnt   saturating statistics
//   wd_err                  sticky watchdog error (too long in WAIT)
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             d_valid,
    input  logic             d_is_branch,
    input  logic [2:0]       d_cmpop,
    input  logic [31:0]      d_pc,
    input  logic [15:0]      d_imm16,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             cmp_bmove,
    output logic [2:0]       cmp_op,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    output logic             stall_d,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             wd_err
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0]  CNT_SAT    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               wd_err_q, wd_err_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
    logic [2:0]         cmp_op_q;
    logic [31:0]        cmp_a_q, cmp_b_q, redirect_pc_q;

    logic               branch_req_s;
    logic               need_rt_s;
    logic               ready_s;
    logic               latch_s;
    logic               stall_s;
    logic               redirect_s;
    logic [WAIT_W-1:0]  wait_inc_s;
    logic [31:0]        target_s;

    // Operand readiness and branch target of the instruction currently in D
    always_comb begin
        branch_req_s = d_valid & d_is_branch;
        // Only eq/ne compare two registers; the zero-compares ignore rt.
        need_rt_s    = (d_cmpop <= 3'd1);
        ready_s      = rs_ready & (rt_ready | ~need_rt_s);
        target_s     = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
        // Saturate so a very long stall cannot wrap the watchdog count.
        if (wait_cnt_q == WAIT_LIMIT) begin
            wait_inc_s = wait_cnt_q;
        end else begin
            wait_inc_s = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Next-state, datapath enables and combinational outputs
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        wd_err_d     = wd_err_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        latch_s      = 1'b0;
        stall_s      = 1'b0;
        redirect_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_s = branch_req_s;
                if (branch_req_s) begin
                    if (ready_s) begin
                        latch_s = 1'b1;
                        state_d = ST_RESOLVE;
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_s    = 1'b1;
                wait_cnt_d = wait_inc_s;
                if (wait_inc_s == WAIT_LIMIT) begin
                    wd_err_d = 1'b1;
                end else begin
                    wd_err_d = wd_err_q;
                end
                if (ready_s) begin
                    latch_s = 1'b1;
                    state_d = ST_RESOLVE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESOLVE: begin
                // stall_d stays low: the branch leaves D and the delay slot enters.
                redirect_s = cmp_bmove;
                if (branch_cnt_q == CNT_SAT) begin
                    branch_cnt_d = branch_cnt_q;
                end else begin
                    branch_cnt_d = branch_cnt_q + CNT_W'(1);
                end
                if (cmp_bmove && (taken_cnt_q != CNT_SAT)) begin
                    taken_cnt_d = taken_cnt_q + CNT_W'(1);
                end else begin
                    taken_cnt_d = taken_cnt_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush discards the branch: no redirect, no statistics, no watchdog
        // progress, and the comparator registers keep their last contents.
        if (flush) begin
            state_d      = ST_IDLE;
            latch_s      = 1'b0;
            redirect_s   = 1'b0;
            wait_cnt_d   = wait_cnt_q;
            wd_err_d     = wd_err_q;
            branch_cnt_d = branch_cnt_q;
            taken_cnt_d  = taken_cnt_q;
        end else begin
            state_d = state_d;
        end
    end

    // State, statistics, watchdog and comparator/target registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            wd_err_q      <= 1'b0;
            branch_cnt_q  <= '0;
            taken_cnt_q   <= '0;
            cmp_op_q      <= 3'd0;
            cmp_a_q       <= 32'd0;
            cmp_b_q       <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            wd_err_q     <= wd_err_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            if (latch_s) begin
                cmp_op_q      <= d_cmpop;
                cmp_a_q       <= rs_val;
                cmp_b_q       <= rt_val;
                redirect_pc_q <= target_s;
            end
        end
    end

    assign cmp_op      = cmp_op_q;
    assign cmp_a       = cmp_a_q;
    assign cmp_b       = cmp_b_q;
    assign redirect_pc = redirect_pc_q;
    assign stall_d     = stall_s;
    assign redirect    = redirect_s;
    assign busy        = (state_q != ST_IDLE);
    assign branch_cnt  = branch_cnt_q;
    assign taken_cnt   = taken_cnt_q;
    assign wd_err      = wd_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

    localparam int CNT_W    = 2;
    localparam int WAIT_MAX = 15;
    localparam int CNT_TOP  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, flush, d_valid, d_is_branch;
    logic [2:0]       d_cmpop;
    logic [31:0]      d_pc;
    logic [15:0]      d_imm16;
    logic             rs_ready, rt_ready;
    logic [31:0]      rs_val, rt_val;
    logic             cmp_bmove;
    logic [2:0]       cmp_op;
    logic [31:0]      cmp_a, cmp_b;
    logic             stall_d, redirect, busy, wd_err;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: architectural view of the statistics
    int   exp_branch;
    int   exp_taken;
    logic exp_wd;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
        .d_is_branch(d_is_branch), .d_cmpop(d_cmpop), .d_pc(d_pc), .d_imm16(d_imm16),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .rs_val(rs_val), .rt_val(rt_val),
        .cmp_bmove(cmp_bmove), .cmp_op(cmp_op), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .wd_err(wd_err)
    );

    // MIPS branch condition; also serves as the comparator attached to the DUT
    function automatic logic branch_taken(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) <= 32'sd0;
            3'd3:    return $signed(a) >  32'sd0;
            3'd4:    return $signed(a) <  32'sd0;
            3'd5:    return $signed(a) >= 32'sd0;
            default: return 1'b0;
        endcase
    endfunction

    assign cmp_bmove = branch_taken(cmp_op, cmp_a, cmp_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        flush       = 1'b0;
        d_valid     = 1'b0;
        d_is_branch = 1'b0;
        d_cmpop     = 3'($urandom_range(0, 7));
        d_pc        = $urandom;
        d_imm16     = 16'($urandom);
        rs_ready    = 1'($urandom);
        rt_ready    = 1'($urandom);
        rs_val      = $urandom;
        rt_val      = $urandom;
    endtask

    // Quiet cycle after a branch: FSM back in IDLE, statistics settled
    task automatic check_settled(input string tag);
        drive_idle();
        @(negedge clk);
        chk({tag, ".busy"},  32'(busy), 32'd0);
        chk({tag, ".stall"}, 32'(stall_d), 32'd0);
        chk({tag, ".redir"}, 32'(redirect), 32'd0);
        chk({tag, ".bcnt"},  32'(branch_cnt), 32'(exp_branch));
        chk({tag, ".tcnt"},  32'(taken_cnt), 32'(exp_taken));
        chk({tag, ".wd"},    32'(wd_err), 32'(exp_wd));
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        drive_idle();
        reset       = 1'b1;
        flush       = 1'b1;   // reset must win over flush
        d_valid     = 1'b1;
        d_is_branch = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        drive_idle();
        exp_branch = 0;
        exp_taken  = 0;
        exp_wd     = 1'b0;
        @(negedge clk);
        chk({tag, ".cmp_op"}, 32'(cmp_op), 32'd0);
        chk({tag, ".cmp_a"},  cmp_a, 32'd0);
        chk({tag, ".cmp_b"},  cmp_b, 32'd0);
        chk({tag, ".rpc"},    redirect_pc, 32'd0);
        chk({tag, ".busy"},   32'(busy), 32'd0);
        chk({tag, ".bcnt"},   32'(branch_cnt), 32'd0);
        chk({tag, ".tcnt"},   32'(taken_cnt), 32'd0);
        chk({tag, ".wd"},     32'(wd_err), 32'd0);
        @(posedge clk); #1;
    endtask

    // One branch presented in D until it leaves (or is flushed).
    // Operand X is available from cycle X_dly on (cycle 0 = first cycle in D);
    // flush_at < 0 means no flush.
    task automatic run_branch(input string tag, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [15:0] imm,
                              input int rs_dly, input int rt_dly, input int flush_at);
        logic        need_rt;
        logic        taken;
        logic        flushed;
        logic [31:0] tgt;
        int          eff;
        int          last;
        int          waits;
        need_rt = (op <= 3'd1);
        eff     = (need_rt && rt_dly > rs_dly) ? rt_dly : rs_dly;
        last    = eff + 1;                        // resolve cycle
        taken   = branch_taken(op, a, b);
        tgt     = pc + 32'd4 + 32'({{16{imm[15]}}, imm} * 4);
        flushed = 1'b0;
        for (int c = 0; c <= last && !flushed; c++) begin
            d_valid     = 1'b1;
            d_is_branch = 1'b1;
            d_cmpop     = op;
            d_pc        = pc;
            d_imm16     = imm;
            rs_ready    = (c >= rs_dly);
            rt_ready    = (c >= rt_dly);
            rs_val      = rs_ready ? a : $urandom;
            rt_val      = rt_ready ? b : $urandom;
            flush       = (c == flush_at);
            @(negedge clk);
            if (c == flush_at) begin
                chk({tag, ".fl_redir"}, 32'(redirect), 32'd0);
                flushed = 1'b1;
            end else if (c < last) begin
                chk({tag, ".stall"}, 32'(stall_d), 32'd1);
                chk({tag, ".redir0"}, 32'(redirect), 32'd0);
                chk({tag, ".busy"}, 32'(busy), 32'(c > 0));
            end else begin
                chk({tag, ".rs_stall"}, 32'(stall_d), 32'd0);
                chk({tag, ".rs_busy"}, 32'(busy), 32'd1);
                chk({tag, ".redir"}, 32'(redirect), 32'(taken));
                chk({tag, ".rpc"}, redirect_pc, tgt);
                chk({tag, ".cmp_op"}, 32'(cmp_op), 32'(op));
                chk({tag, ".cmp_a"}, cmp_a, a);
                if (need_rt) chk({tag, ".cmp_b"}, cmp_b, b);
            end
            @(posedge clk); #1;
        end
        // statistics and watchdog, from the transaction's outcome
        if (!flushed) begin
            if (exp_branch < CNT_TOP) exp_branch++;
            if (taken && exp_taken < CNT_TOP) exp_taken++;
            waits = eff;
        end else begin
            waits = (flush_at == 0) ? 0 : ((flush_at - 1 < eff) ? flush_at - 1 : eff);
        end
        if (waits >= WAIT_MAX) exp_wd = 1'b1;
        check_settled(tag);
    endtask

    initial begin
        int op, a, b, rsd, rtd, fa, eff;
        reset = 1'b0;
        drive_idle();
        exp_branch = 0;
        exp_taken  = 0;
        exp_wd     = 1'b0;
        @(posedge clk); #1;

        do_reset("rst0");
        // beq taken, operands ready at entry
        run_branch("beq", 3'd0, 32'd5, 32'd5, 32'h0000_3000, 16'd4, 0, 0, -1);
        do_reset("rst1");
        // bne not taken
        run_branch("bne", 3'd1, 32'd7, 32'd7, 32'h0000_3000, 16'd4, 0, 0, -1);
        // bgez: rs late by 3 cycles, rt never ready and not needed
        run_branch("bgez", 3'd5, 32'h0000_0010, 32'd0, 32'h0000_4000, 16'hFFFF, 3, 1000, -1);
        // flush while waiting, then while resolving
        run_branch("flw", 3'd0, 32'd1, 32'd1, 32'h0000_5000, 16'd8, 5, 0, 2);
        run_branch("flr", 3'd0, 32'd9, 32'd9, 32'h0000_5000, 16'd8, 1, 1, 2);
        run_branch("fli", 3'd0, 32'd9, 32'd9, 32'h0000_5000, 16'd8, 0, 0, 0);
        // opcodes 6/7 never taken but counted
        run_branch("op7", 3'd7, 32'd0, 32'd0, 32'h0000_6000, 16'd1, 0, 0, -1);
        // watchdog
        do_reset("rst2");
        run_branch("wd", 3'd4, 32'hFFFF_FFFF, 32'd0, 32'h0000_7000, 16'd2, 16, 0, -1);
        run_branch("wd_hold", 3'd0, 32'd3, 32'd3, 32'h0000_7000, 16'd2, 0, 0, -1);
        do_reset("rst3");
        // target wrap and saturation of the taken counter
        for (int i = 0; i < 5; i++)
            run_branch("wrap", 3'd0, 32'd2, 32'd2, 32'hFFFF_FFF0, 16'hFFF8, 0, 0, -1);

        // randomized transactions against the reference model
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 24) == 0) do_reset("rrst");
            op  = $urandom_range(0, 7);
            a   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom);
            if ($urandom_range(0, 7) == 0) a = -int'($urandom_range(1, 9));
            b   = ($urandom_range(0, 1) == 0) ? a : int'($urandom);
            rsd = ($urandom_range(0, 15) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            rtd = $urandom_range(0, 3);
            eff = (op <= 1 && rtd > rsd) ? rtd : rsd;
            fa  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, eff + 1) : -1;
            run_branch("rnd", 3'(op), 32'(a), 32'(b), $urandom, 16'($urandom),
                       rsd, rtd, fa);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
